// File: rtl/servant_spi_fram_slave.sv
// Purpose: SPI FRAM-style slave with opcodes WREN/WRDI/RDSR/WRITE/READ, backed by an internal byte array.
// Latency: edges seen 3 clocks after the pins; read data is loaded 2 clocks after byte completion and shows on MISO at the next sck fall.
// Backpressure: none; the SPI master owns pacing and the core clock must run at >= 8x sck.
module servant_spi_fram_slave #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int MEM_BYTES     = 1024,
    parameter int WEL_STICKY    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       wel_out,
    output logic       active,
    output logic [7:0] last_cmd
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, STATUS, IGNORE} state_t;

    state_t                   state;
    logic                     sck_s1, sck_s2, sck_s3;
    logic                     ss_s1, ss_s2, ss_s3;
    logic                     mosi_s1, mosi_s2;
    logic [2:0]               warm;
    logic [2:0]               bit_cnt;
    logic [6:0]               rx_sr;
    logic [ADDRESS_WIDTH-9:0] addr_sr;
    logic [1:0]               addr_cnt;
    logic [AW-1:0]            addr;
    logic                     wel;
    logic                     wrote;
    logic [7:0]               tx_sr;
    logic                     tx_load;
    logic [7:0]               rd_data;
    logic [7:0]               mem [MEM_BYTES];

    logic                     edges_ok, sck_rise, sck_fall, ss_fall, ss_rise;
    logic                     byte_done, wr_fire, rd_fire;
    logic [7:0]               rx_byte;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic [AW-1:0]            rd_addr;
    logic                     addr_top_unused;

    // Synchronize the SPI pins; warm tracks when every stage holds a real sample so
    // reset values are never mistaken for edges (a held-low select needs a fresh fall).
    always_ff @(posedge clock) begin
        if (!reset) begin
            sck_s1  <= 1'b1;
            sck_s2  <= 1'b1;
            sck_s3  <= 1'b1;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            warm    <= 3'b000;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            ss_s1   <= spi_ss;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            warm    <= {warm[1:0], 1'b1};
        end
    end

    assign edges_ok  = warm[2];
    assign sck_rise  = edges_ok & sck_s2 & ~sck_s3;
    assign sck_fall  = edges_ok & ~sck_s2 & sck_s3;
    assign ss_fall   = edges_ok & ~ss_s2 & ss_s3;
    assign ss_rise   = edges_ok & ss_s2 & ~ss_s3;
    assign active    = ~ss_s2;
    assign wel_out   = wel;

    // A select rise implies ss_s2 high, so ~ss_s2 also gives deselect priority over sck.
    assign byte_done = sck_rise & (bit_cnt == 3'd7) & ~ss_s2 & (state != IDLE);
    assign rx_byte   = {rx_sr, mosi_s2};
    assign addr_next = {addr_sr, rx_byte};
    assign wr_fire   = reset & byte_done & (state == WRITE) & wel;
    assign rd_fire   = reset & byte_done &
                       ((state == READ) | ((state == ADDR) & (addr_cnt == 2'd2) & (last_cmd == 8'h03)));
    assign rd_addr   = (state == READ) ? addr : addr_next[AW-1:0];
    // Address bits above the array size are accepted on the wire and ignored.
    assign addr_top_unused = ^addr_next[ADDRESS_WIDTH-1:ADDRESS_WIDTH-8];

    // Byte array: no reset so contents survive reset and deselect; registered read port.
    always_ff @(posedge clock) begin
        if (wr_fire) mem[addr] <= rx_byte;
        if (rd_fire) rd_data <= mem[rd_addr];
    end

    // Bit/byte framing, command decode, address tracking and MISO shifting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            addr_sr  <= '0;
            addr_cnt <= 2'd0;
            addr     <= '0;
            wel      <= 1'b0;
            wrote    <= 1'b0;
            tx_sr    <= 8'd0;
            tx_load  <= 1'b0;
            spi_miso <= 1'b0;
            last_cmd <= 8'h00;
        end else begin
            tx_load <= rd_fire;
            if (ss_s2) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= {rx_sr[5:0], mosi_s2};
            end

            if (ss_rise) begin
                state    <= IDLE;
                spi_miso <= 1'b0;
                if ((WEL_STICKY == 0) && (state == WRITE) && wrote) wel <= 1'b0;
            end else begin
                if (ss_s2)
                    spi_miso <= 1'b0;
                else if (sck_fall)
                    spi_miso <= ((state == READ) || (state == STATUS)) ? tx_sr[7] : 1'b0;

                if (tx_load)
                    tx_sr <= rd_data;
                else if (sck_fall)
                    tx_sr <= {tx_sr[6:0], 1'b0};

                case (state)
                    IDLE: begin
                        if (ss_fall) begin
                            state <= CMD;
                            wrote <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (byte_done) begin
                            last_cmd <= rx_byte;
                            case (rx_byte)
                                8'h06: begin wel <= 1'b1; state <= IGNORE; end
                                8'h04: begin wel <= 1'b0; state <= IGNORE; end
                                8'h05: begin
                                    state <= STATUS;
                                    tx_sr <= {6'b0, wel, 1'b0};
                                end
                                8'h02, 8'h03: begin
                                    state    <= ADDR;
                                    addr_cnt <= 2'd0;
                                end
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: begin
                        if (byte_done) begin
                            addr_sr  <= addr_next[ADDRESS_WIDTH-9:0];
                            addr_cnt <= addr_cnt + 2'd1;
                            if (addr_cnt == 2'd2) begin
                                if (last_cmd == 8'h03) begin
                                    state <= READ;
                                    addr  <= addr_next[AW-1:0] + 1'b1;
                                end else begin
                                    state <= WRITE;
                                    addr  <= addr_next[AW-1:0];
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (byte_done && wel) begin
                            addr  <= addr + 1'b1;
                            wrote <= 1'b1;
                        end
                    end
                    READ: begin
                        if (byte_done) addr <= addr + 1'b1;
                    end
                    STATUS: begin
                        if (byte_done) tx_sr <= {6'b0, wel, 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_servant_spi_fram_slave.sv
// Purpose: directed bench for servant_spi_fram_slave (sticky and non-sticky WEL instances).
// Latency: SPI bit period is 10 core clocks; all driving and sampling happens on the clock falling edge.
// Backpressure: none; the bench is the SPI master.
module tb_servant_spi_fram_slave;
    logic       clock;
    logic       reset;
    logic       spi_sck;
    logic       spi_ss;
    logic       spi_ss0;
    logic       spi_mosi;
    logic       spi_miso, spi_miso0;
    logic       wel_out, wel_out0;
    logic       active, active0;
    logic [7:0] last_cmd, last_cmd0;

    int         checks;
    int         errors;
    int         sel;
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];

    servant_spi_fram_slave dut (
        .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .wel_out(wel_out),
        .active(active), .last_cmd(last_cmd)
    );

    servant_spi_fram_slave #(.WEL_STICKY(0)) dut0 (
        .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss0),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso0), .wel_out(wel_out0),
        .active(active0), .last_cmd(last_cmd0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sck  = 1'b0;
            spi_mosi = tx[i];
            repeat (5) @(negedge clock);
            rx = {rx[6:0], (sel == 0) ? spi_miso : spi_miso0};
            spi_sck = 1'b1;
            repeat (5) @(negedge clock);
        end
    endtask

    task automatic sel_lo();
        if (sel == 0) spi_ss = 1'b0; else spi_ss0 = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic sel_hi();
        repeat (4) @(negedge clock);
        spi_ss  = 1'b1;
        spi_ss0 = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic xfer(input int n);
        logic [7:0] r;
        sel_lo();
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, r);
            rx_buf[i] = r;
        end
        sel_hi();
    endtask

    task automatic cmd(input logic [7:0] op);
        tx_buf[0] = op;
        xfer(1);
    endtask

    task automatic mem_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int nd);
        tx_buf[0] = 8'h02; tx_buf[1] = a[23:16]; tx_buf[2] = a[15:8]; tx_buf[3] = a[7:0];
        tx_buf[4] = d0;    tx_buf[5] = d1;
        xfer(4 + nd);
    endtask

    task automatic mem_read(input logic [23:0] a, input int nd);
        tx_buf[0] = 8'h03; tx_buf[1] = a[23:16]; tx_buf[2] = a[15:8]; tx_buf[3] = a[7:0];
        tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
        xfer(4 + nd);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0; spi_sck = 1'b1; spi_ss = 1'b1; spi_ss0 = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b want 0", spi_miso); end
        checks++; if (wel_out !== 1'b0) begin errors++; $display("FAIL rst_wel: got %b want 0", wel_out); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", active); end
        checks++; if (last_cmd !== 8'h00) begin errors++; $display("FAIL rst_last_cmd: got %h want 00", last_cmd); end
        reset = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic test_write_read();
        cmd(8'h06);
        checks++; if (wel_out !== 1'b1) begin errors++; $display("FAIL wren_wel: got %b want 1", wel_out); end
        checks++; if (last_cmd !== 8'h06) begin errors++; $display("FAIL wren_last_cmd: got %h want 06", last_cmd); end
        mem_write(24'h000010, 8'hA5, 8'h5A, 2);
        mem_read(24'h000010, 2);
        checks++; if (rx_buf[4] !== 8'hA5) begin errors++; $display("FAIL rd_byte0: got %h want a5", rx_buf[4]); end
        checks++; if (rx_buf[5] !== 8'h5A) begin errors++; $display("FAIL rd_byte1: got %h want 5a", rx_buf[5]); end
        checks++; if (wel_out !== 1'b1) begin errors++; $display("FAIL rd_wel: got %b want 1", wel_out); end
        checks++; if (last_cmd !== 8'h03) begin errors++; $display("FAIL rd_last_cmd: got %h want 03", last_cmd); end
    endtask

    task automatic test_write_protect();
        cmd(8'h06);
        mem_write(24'h000020, 8'h3C, 8'h00, 1);
        pulse_reset();
        checks++; if (wel_out !== 1'b0) begin errors++; $display("FAIL wp_reset_wel: got %b want 0", wel_out); end
        mem_write(24'h000020, 8'h77, 8'h00, 1);
        mem_read(24'h000020, 1);
        checks++; if (rx_buf[4] !== 8'h3C) begin errors++; $display("FAIL wp_data: got %h want 3c", rx_buf[4]); end
        checks++; if (wel_out !== 1'b0) begin errors++; $display("FAIL wp_wel: got %b want 0", wel_out); end
    endtask

    task automatic test_wrap();
        cmd(8'h06);
        mem_write(24'h0003FF, 8'h11, 8'h22, 2);
        mem_read(24'h000000, 1);
        checks++; if (rx_buf[4] !== 8'h22) begin errors++; $display("FAIL wrap_rd0: got %h want 22", rx_buf[4]); end
        mem_read(24'h0003FF, 2);
        checks++; if (rx_buf[4] !== 8'h11) begin errors++; $display("FAIL wrap_rd1023: got %h want 11", rx_buf[4]); end
        checks++; if (rx_buf[5] !== 8'h22) begin errors++; $display("FAIL wrap_rd_next: got %h want 22", rx_buf[5]); end
    endtask

    task automatic test_status();
        cmd(8'h06);
        tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        xfer(3);
        checks++; if (rx_buf[1] !== 8'h02) begin errors++; $display("FAIL sr_wel1_a: got %h want 02", rx_buf[1]); end
        checks++; if (rx_buf[2] !== 8'h02) begin errors++; $display("FAIL sr_wel1_b: got %h want 02", rx_buf[2]); end
        cmd(8'h04);
        checks++; if (wel_out !== 1'b0) begin errors++; $display("FAIL wrdi_wel: got %b want 0", wel_out); end
        tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        xfer(3);
        checks++; if (rx_buf[1] !== 8'h00) begin errors++; $display("FAIL sr_wel0_a: got %h want 00", rx_buf[1]); end
        checks++; if (rx_buf[2] !== 8'h00) begin errors++; $display("FAIL sr_wel0_b: got %h want 00", rx_buf[2]); end
    endtask

    task automatic test_partial_abort();
        logic [7:0] r;
        cmd(8'h06);
        mem_write(24'h000030, 8'h99, 8'h00, 1);
        sel_lo();
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h30, 8, r);
        spi_bits(8'hFF, 5, r);
        spi_ss = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL abort_active: got %b want 0", active); end
        checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL abort_miso: got %b want 0", spi_miso); end
        repeat (6) @(negedge clock);
        mem_read(24'h000030, 1);
        checks++; if (rx_buf[4] !== 8'h99) begin errors++; $display("FAIL abort_data: got %h want 99", rx_buf[4]); end
    endtask

    task automatic test_reset_midtransfer();
        logic [7:0] r;
        cmd(8'h06);
        sel_lo();
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        pulse_reset();
        checks++; if (wel_out !== 1'b0) begin errors++; $display("FAIL midrst_wel: got %b want 0", wel_out); end
        spi_bits(8'h06, 8, r);
        checks++; if (wel_out !== 1'b0) begin errors++; $display("FAIL midrst_nodecode_wel: got %b want 0", wel_out); end
        checks++; if (last_cmd !== 8'h00) begin errors++; $display("FAIL midrst_nodecode_cmd: got %h want 00", last_cmd); end
        sel_hi();
        cmd(8'h06);
        checks++; if (wel_out !== 1'b1) begin errors++; $display("FAIL midrst_fresh_wel: got %b want 1", wel_out); end
    endtask

    task automatic test_wel_nonsticky();
        sel = 1;
        cmd(8'h06);
        checks++; if (wel_out0 !== 1'b1) begin errors++; $display("FAIL ns_wren: got %b want 1", wel_out0); end
        mem_write(24'h000040, 8'h5A, 8'h00, 1);
        checks++; if (wel_out0 !== 1'b0) begin errors++; $display("FAIL ns_wel_cleared: got %b want 0", wel_out0); end
        mem_write(24'h000040, 8'hFF, 8'h00, 1);
        mem_read(24'h000040, 1);
        checks++; if (rx_buf[4] !== 8'h5A) begin errors++; $display("FAIL ns_second_write: got %h want 5a", rx_buf[4]); end
        sel = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel    = 0;
        test_reset();
        test_write_read();
        test_write_protect();
        test_wrap();
        test_status();
        test_partial_abort();
        test_reset_midtransfer();
        test_wel_nonsticky();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
